// File: rtl/drbg_keystream_pingpong.sv
// DRBG keystream buffer with N-bank ping-pong storage.
// Wide DRBG blocks are captured into empty banks while the other banks are
// drained one DATA_WIDTH_OUT word per H rising edge during active video.
// A V rising edge flushes every bank and restarts keystream alignment.
module drbg_keystream_pingpong #(
  parameter int DATA_WIDTH_IN    = 256,
  parameter int DATA_WIDTH_OUT   = 8,
  parameter int NUM_BANKS        = 2,
  parameter int BUSY_IDLE_CYCLES = 8,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      H,
  input  logic                      V,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      data_in_valid,
  input  logic                      generator_busy,
  output logic                      need_next,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      data_out_valid,
  output logic                      underrun,
  output logic [CNT_WIDTH-1:0]      underrun_count
);

  localparam int WORDS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int RAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BKW   = $clog2(NUM_BANKS);
  localparam int ICW   = $clog2(BUSY_IDLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} fill_state_t;

  fill_state_t state, state_nxt;

  logic [NUM_BANKS-1:0][DATA_WIDTH_IN-1:0] bank;
  logic [NUM_BANKS-1:0]                    full;
  logic [BKW-1:0]                          wb, rb;
  logic [RAW-1:0]                          ra;
  logic [ICW-1:0]                          idle_cnt;
  logic                                    prev_h, prev_v;
  logic                                    h_rise, v_rise, rd_act;
  logic                                    req, fill;
  logic [BKW-1:0]                          fill_idx;
  logic [WORDS-1:0][DATA_WIDTH_OUT-1:0]    rd_words;

  assign h_rise   = H & ~prev_h;
  assign v_rise   = V & ~prev_v;
  assign rd_act   = h_rise & ~V;
  // A block arriving on the flush cycle becomes the first block of the new frame.
  assign fill_idx = v_rise ? '0 : wb;
  assign rd_words = bank[rb];

  // Fill FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Fill FSM next state; a pending request in WAIT survives a frame restart
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!v_rise && !full[wb]) state_nxt = SETTLE;
      SETTLE:  if (v_rise)               state_nxt = IDLE;
               else if (req)             state_nxt = WAIT;
      WAIT:    if (data_in_valid)        state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Fill FSM outputs: request once the generator has been quiet long enough
  always_comb begin
    req  = (state == SETTLE) && !v_rise && !generator_busy &&
           (idle_cnt == ICW'(BUSY_IDLE_CYCLES - 1));
    fill = (state == WAIT) && data_in_valid;
  end

  // Consecutive busy-low counter used while settling
  always_ff @(posedge clk) begin
    if (!reset_n || state != SETTLE || generator_busy) idle_cnt <= '0;
    else if (!req)                                   idle_cnt <= idle_cnt + 1'b1;
  end

  // Bank payload storage; validity lives in full[], so no reset is needed here
  always_ff @(posedge clk) begin
    if (reset_n && fill) bank[fill_idx] <= data_in;
  end

  // Sync edge registers, bank bookkeeping, read path and status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_h         <= 1'b0;
      prev_v         <= 1'b0;
      full           <= '0;
      wb             <= '0;
      rb             <= '0;
      ra             <= '0;
      need_next      <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      prev_h         <= H;
      prev_v         <= V;
      need_next      <= req;
      data_out_valid <= 1'b0;
      underrun       <= 1'b0;
      if (v_rise) begin
        full <= '0;
        rb   <= '0;
        ra   <= '0;
        if (fill) begin
          full[0] <= 1'b1;
          wb      <= BKW'(1);
        end else begin
          wb      <= '0;
        end
      end else begin
        if (fill) begin
          full[wb] <= 1'b1;
          wb       <= wb + 1'b1;
        end
        if (rd_act) begin
          if (full[rb]) begin
            data_out       <= rd_words[ra];
            data_out_valid <= 1'b1;
            if (ra == RAW'(WORDS - 1)) begin
              ra       <= '0;
              full[rb] <= 1'b0;
              rb       <= rb + 1'b1;
            end else begin
              ra <= ra + 1'b1;
            end
          end else begin
            underrun <= 1'b1;
            if (underrun_count != '1) underrun_count <= underrun_count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_drbg_keystream_pingpong.sv
// Directed bench for drbg_keystream_pingpong: fill/request handshake, word
// ordering across banks, underrun, frame restart, reset in WAIT, saturation.
module tb_drbg_keystream_pingpong;

  localparam int DW_IN  = 256;
  localparam int DW_OUT = 8;
  localparam int CW     = 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              H = 1'b0;
  logic              V = 1'b0;
  logic [DW_IN-1:0]  data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              generator_busy = 1'b0;
  logic              need_next;
  logic [DW_OUT-1:0] data_out;
  logic              data_out_valid;
  logic              underrun;
  logic [CW-1:0]     underrun_count;

  int vectors  = 0;
  int errs     = 0;
  int req_pend = 0;
  int ucnt     = 0;
  int first    = 0;
  int p0       = 0;

  drbg_keystream_pingpong #(
    .DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .NUM_BANKS(2),
    .BUSY_IDLE_CYCLES(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .H(H), .V(V),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .generator_busy(generator_busy), .need_next(need_next),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
    if (need_next) req_pend++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW_IN-1:0] mkblk(input logic [7:0] base);
    logic [DW_IN-1:0] b;
    for (int k = 0; k < 32; k++) b[k*8 +: 8] = base + 8'(k);
    return b;
  endfunction

  // Wait (bounded) for an outstanding request, then answer it with one block.
  task automatic serve(input logic [7:0] base, input string tag);
    int n;
    n = 0;
    while (req_pend == 0 && n < 60) begin step(); n++; end
    chk($sformatf("%s req", tag), 32'(req_pend > 0), 1);
    if (req_pend > 0) req_pend--;
    data_in = mkblk(base); data_in_valid = 1'b1; step();
    data_in_valid = 1'b0;
  endtask

  // One H pulse with V low; exp_v=0 means an underrun is expected.
  task automatic hrise(input string tag, input bit exp_v, input logic [7:0] exp_d);
    H = 1'b1; step();
    if (!exp_v && ucnt < 63) ucnt++;
    chk($sformatf("%s valid", tag), data_out_valid, exp_v);
    chk($sformatf("%s underrun", tag), underrun, !exp_v);
    chk($sformatf("%s data", tag), data_out, exp_d);
    chk($sformatf("%s count", tag), underrun_count, ucnt);
    H = 1'b0; step();
    chk($sformatf("%s strobe end", tag), data_out_valid | underrun, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s need_next", tag), need_next, 0);
    chk($sformatf("%s data_out", tag), data_out, 0);
    chk($sformatf("%s valid", tag), data_out_valid, 0);
    chk($sformatf("%s underrun", tag), underrun, 0);
    chk($sformatf("%s count", tag), underrun_count, 0);
  endtask

  initial begin
    // reset state
    step(); step();
    chk_zero("reset");
    reset_n = 1'b1; req_pend = 0;

    // first request after 8 busy-low settle cycles
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin step(); if (need_next) first = i; end
    chk("first req cycle", first, 9);
    step();
    chk("req one-shot", need_next, 0);

    // two blocks then 64 words in block/word order
    serve(8'h01, "fillA");
    serve(8'h80, "fillB");
    for (int k = 0; k < 64; k++)
      hrise("rdAB", 1'b1, (k < 32) ? 8'(k + 1) : 8'(8'h80 + k - 32));

    // drained: underruns, data held
    hrise("urun1", 1'b0, 8'h9F);
    hrise("urun2", 1'b0, 8'h9F);
    hrise("urun3", 1'b0, 8'h9F);

    // busy filtering: 20 busy, 7 quiet, 1 busy, then 8 quiet needed
    serve(8'h40, "fillC");
    generator_busy = 1'b1; p0 = req_pend;
    repeat (20) step();
    generator_busy = 1'b0;
    repeat (7) step();
    generator_busy = 1'b1; step();
    chk("busy no early req", req_pend - p0, 0);
    generator_busy = 1'b0; first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin step(); if (need_next) first = i; end
    chk("busy req cycle", first, 8);

    // 10 words, then frame restart with a request in WAIT
    for (int k = 0; k < 10; k++) hrise("rdC", 1'b1, 8'(8'h40 + k));
    V = 1'b1; step();
    chk("vrise valid", data_out_valid, 0);
    H = 1'b1; step();
    chk("blank H valid", data_out_valid, 0);
    chk("blank H underrun", underrun, 0);
    H = 1'b0; step();
    serve(8'hC0, "fillD");
    V = 1'b0; step();
    hrise("vfirst", 1'b1, 8'hC0);

    // H and V rise together: no read, alignment reset
    H = 1'b1; V = 1'b1; step();
    chk("HV valid", data_out_valid, 0);
    chk("HV underrun", underrun, 0);
    chk("HV count", underrun_count, ucnt);
    H = 1'b0; step();
    serve(8'h60, "fillE");
    serve(8'hA0, "fillF");
    V = 1'b0; step();
    // both banks full: FSM idle, this block must be ignored
    data_in = mkblk(8'hEE); data_in_valid = 1'b1; step();
    data_in_valid = 1'b0;
    for (int k = 0; k < 32; k++) hrise("rdE", 1'b1, 8'(8'h60 + k));
    hrise("rdF0", 1'b1, 8'hA0);

    // reset while waiting, then a late block
    for (int n = 0; n < 60 && req_pend == 0; n++) step();
    chk("refill req", 32'(req_pend > 0), 1);
    reset_n = 1'b0; step();
    chk_zero("midreset");
    req_pend = 0; ucnt = 0;
    reset_n = 1'b1;
    data_in = mkblk(8'h11); data_in_valid = 1'b1; step();
    data_in_valid = 1'b0;
    hrise("post rst", 1'b0, 8'h00);

    // counter saturation at all-ones
    for (int k = 0; k < 66; k++) hrise("sat", 1'b0, 8'h00);
    chk("sat final", underrun_count, 63);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
